// File: rtl/axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter
//
// N-master request arbiter in front of the single AXI bridge request port.
// The read and write channels are independent. Each channel has its own
// IDLE/BUSY grant FSM, its own round-robin pointer (or fixed priority), and
// its own burst-beat counter. The counter raises a sticky error when `last`
// arrives early or late relative to the latched burst length.
//
// Ports (N = NUM_MASTERS, DW = AXI_DATA_WIDTH, AW = AXI_ADDR_WIDTH):
//   clk, rst                       clock, synchronous active-high reset
//   m_r_valid/addr/len/size        per-master read requests (packed, master i
//                                  at [i*W +: W])
//   m_r_ready/last                 bridge read beat/last, granted master only
//   m_r_data                       bridge read data, zero when no read grant
//   m_w_valid/addr/data/len/size   per-master write requests (packed)
//   m_w_ready/last                 bridge write beat/last, granted master only
//   r_*_o, w_*_o                   request fields of the granted master
//   r_ready_i/r_last_i/r_data_i    read beat from the bridge
//   w_ready_i/w_last_i             write beat/last from the bridge
//   rd_grant_o, wr_grant_o         one-hot current grant, 0 when idle
//   rd_err_o, wr_err_o             sticky burst-length mismatch flags
// ---------------------------------------------------------------------------

// One arbitration channel. It carries an opaque per-master payload plus the
// burst length, which it latches for beat checking.
module axi_rr_chan #(
    parameter int N       = 3,
    parameter int PW      = 8,
    parameter int RR_MODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*8-1:0]  req_len,
    input  logic [N*PW-1:0] req_payload,
    input  logic            ready_i,
    input  logic            last_i,
    output logic            valid_o,
    output logic [7:0]      len_o,
    output logic [PW-1:0]   payload_o,
    output logic [N-1:0]    grant_o,
    output logic [N-1:0]    beat_ready_o,
    output logic [N-1:0]    beat_last_o,
    output logic            err_o
);
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] win_q, win_d, ptr_q, ptr_d, sel_idx;
    logic [7:0]    len_q, len_d, cnt_q, cnt_d, sel_len;
    logic          err_q, err_d, sel_found;

    // Winner search: start at ptr (round-robin) or 0 (fixed), wrap upward.
    always_comb begin
        sel_idx   = '0;
        sel_len   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = ((RR_MODE != 0) ? int'(ptr_q) : 0) + k;
            if (idx >= N) idx = idx - N;
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx[IW-1:0];
                sel_len   = req_len[idx*8 +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d          = BUSY;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    win_d            = sel_idx;
                    len_d            = sel_len;
                    cnt_d            = '0;
                end
            end
            BUSY: begin
                if (ready_i) begin
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    if (last_i) begin
                        // Beat index of the last beat must equal beats-1.
                        if (cnt_q != len_q) err_d = 1'b1;
                        state_d = IDLE;
                        grant_d = '0;
                        if (RR_MODE != 0)
                            ptr_d = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
                    end else if (cnt_q == len_q) begin
                        // This beat pushes the count to len+1 with no last.
                        err_d = 1'b1;
                    end
                end else if (cnt_q == 8'd0 && !(|(req_valid & grant_q))) begin
                    // Requester withdrew before any beat: release, keep ptr.
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Grant is one-hot or zero, so the mux collapses to zero when idle.
    always_comb begin
        payload_o = '0;
        len_o     = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                payload_o = req_payload[i*PW +: PW];
                len_o     = req_len[i*8 +: 8];
            end
        end
    end

    assign valid_o      = |(req_valid & grant_q);
    assign grant_o      = grant_q;
    assign beat_ready_o = grant_q & {N{ready_i}};
    assign beat_last_o  = grant_q & {N{last_i}};
    assign err_o        = err_q;
endmodule

module axi_rr_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int RR_MODE        = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTERS-1:0]              m_r_valid,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_r_addr,
    input  logic [NUM_MASTERS*8-1:0]            m_r_len,
    input  logic [NUM_MASTERS*8-1:0]            m_r_size,
    output logic [NUM_MASTERS-1:0]              m_r_ready,
    output logic [NUM_MASTERS-1:0]              m_r_last,
    output logic [AXI_DATA_WIDTH-1:0]           m_r_data,
    input  logic [NUM_MASTERS-1:0]              m_w_valid,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] m_w_addr,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] m_w_data,
    input  logic [NUM_MASTERS*8-1:0]            m_w_len,
    input  logic [NUM_MASTERS*8-1:0]            m_w_size,
    output logic [NUM_MASTERS-1:0]              m_w_ready,
    output logic [NUM_MASTERS-1:0]              m_w_last,
    output logic                                r_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]           r_addr_o,
    output logic [7:0]                          r_len_o,
    output logic [7:0]                          r_size_o,
    input  logic                                r_ready_i,
    input  logic                                r_last_i,
    input  logic [AXI_DATA_WIDTH-1:0]           r_data_i,
    output logic                                w_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]           w_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]           w_data_o,
    output logic [7:0]                          w_len_o,
    output logic [7:0]                          w_size_o,
    input  logic                                w_ready_i,
    input  logic                                w_last_i,
    output logic [NUM_MASTERS-1:0]              rd_grant_o,
    output logic [NUM_MASTERS-1:0]              wr_grant_o,
    output logic                                rd_err_o,
    output logic                                wr_err_o
);
    localparam int N   = NUM_MASTERS;
    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int DW  = AXI_DATA_WIDTH;
    localparam int RPW = AW + 8;       // {size, addr}
    localparam int WPW = AW + DW + 8;  // {size, data, addr}

    logic [N*RPW-1:0] r_payload;
    logic [N*WPW-1:0] w_payload;
    logic [RPW-1:0]   r_payload_sel;
    logic [WPW-1:0]   w_payload_sel;

    always_comb begin
        r_payload = '0;
        w_payload = '0;
        for (int i = 0; i < N; i++) begin
            r_payload[i*RPW +: RPW] = {m_r_size[i*8 +: 8], m_r_addr[i*AW +: AW]};
            w_payload[i*WPW +: WPW] = {m_w_size[i*8 +: 8], m_w_data[i*DW +: DW],
                                       m_w_addr[i*AW +: AW]};
        end
    end

    axi_rr_chan #(.N(N), .PW(RPW), .RR_MODE(RR_MODE)) u_rd (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (m_r_valid),
        .req_len      (m_r_len),
        .req_payload  (r_payload),
        .ready_i      (r_ready_i),
        .last_i       (r_last_i),
        .valid_o      (r_valid_o),
        .len_o        (r_len_o),
        .payload_o    (r_payload_sel),
        .grant_o      (rd_grant_o),
        .beat_ready_o (m_r_ready),
        .beat_last_o  (m_r_last),
        .err_o        (rd_err_o)
    );

    axi_rr_chan #(.N(N), .PW(WPW), .RR_MODE(RR_MODE)) u_wr (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (m_w_valid),
        .req_len      (m_w_len),
        .req_payload  (w_payload),
        .ready_i      (w_ready_i),
        .last_i       (w_last_i),
        .valid_o      (w_valid_o),
        .len_o        (w_len_o),
        .payload_o    (w_payload_sel),
        .grant_o      (wr_grant_o),
        .beat_ready_o (m_w_ready),
        .beat_last_o  (m_w_last),
        .err_o        (wr_err_o)
    );

    assign r_addr_o = r_payload_sel[AW-1:0];
    assign r_size_o = r_payload_sel[AW +: 8];
    assign w_addr_o = w_payload_sel[AW-1:0];
    assign w_data_o = w_payload_sel[AW +: DW];
    assign w_size_o = w_payload_sel[AW+DW +: 8];

    // Read data is shared by all masters; zero it whenever nobody owns it.
    assign m_r_data = (|rd_grant_o) ? r_data_i : '0;
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rr_arbiter
//
// Directed bench for axi_rr_arbiter with 3 masters. A round-robin instance
// (dut) and a fixed-priority instance (dut_fp) share the same stimulus.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_axi_rr_arbiter;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0]    m_r_valid, m_w_valid;
    logic [N*AW-1:0] m_r_addr, m_w_addr;
    logic [N*8-1:0]  m_r_len, m_r_size, m_w_len, m_w_size;
    logic [N*DW-1:0] m_w_data;
    logic            r_ready_i, r_last_i, w_ready_i, w_last_i;
    logic [DW-1:0]   r_data_i;

    logic [N-1:0]  m_r_ready, m_r_last, m_w_ready, m_w_last, rd_grant_o, wr_grant_o;
    logic [DW-1:0] m_r_data, w_data_o;
    logic [AW-1:0] r_addr_o, w_addr_o;
    logic [7:0]    r_len_o, r_size_o, w_len_o, w_size_o;
    logic          r_valid_o, w_valid_o, rd_err_o, wr_err_o;

    logic [N-1:0]  fp_m_r_ready, fp_m_r_last, fp_m_w_ready, fp_m_w_last;
    logic [N-1:0]  fp_rd_grant, fp_wr_grant;
    logic [DW-1:0] fp_m_r_data, fp_w_data_o;
    logic [AW-1:0] fp_r_addr_o, fp_w_addr_o;
    logic [7:0]    fp_r_len_o, fp_r_size_o, fp_w_len_o, fp_w_size_o;
    logic          fp_r_valid_o, fp_w_valid_o, fp_rd_err, fp_wr_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_rr_arbiter #(.NUM_MASTERS(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                     .RR_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .m_r_valid(m_r_valid), .m_r_addr(m_r_addr), .m_r_len(m_r_len), .m_r_size(m_r_size),
        .m_r_ready(m_r_ready), .m_r_last(m_r_last), .m_r_data(m_r_data),
        .m_w_valid(m_w_valid), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
        .m_w_len(m_w_len), .m_w_size(m_w_size),
        .m_w_ready(m_w_ready), .m_w_last(m_w_last),
        .r_valid_o(r_valid_o), .r_addr_o(r_addr_o), .r_len_o(r_len_o), .r_size_o(r_size_o),
        .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_data_i(r_data_i),
        .w_valid_o(w_valid_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .w_len_o(w_len_o), .w_size_o(w_size_o),
        .w_ready_i(w_ready_i), .w_last_i(w_last_i),
        .rd_grant_o(rd_grant_o), .wr_grant_o(wr_grant_o),
        .rd_err_o(rd_err_o), .wr_err_o(wr_err_o)
    );

    axi_rr_arbiter #(.NUM_MASTERS(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                     .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m_r_valid(m_r_valid), .m_r_addr(m_r_addr), .m_r_len(m_r_len), .m_r_size(m_r_size),
        .m_r_ready(fp_m_r_ready), .m_r_last(fp_m_r_last), .m_r_data(fp_m_r_data),
        .m_w_valid(m_w_valid), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
        .m_w_len(m_w_len), .m_w_size(m_w_size),
        .m_w_ready(fp_m_w_ready), .m_w_last(fp_m_w_last),
        .r_valid_o(fp_r_valid_o), .r_addr_o(fp_r_addr_o), .r_len_o(fp_r_len_o),
        .r_size_o(fp_r_size_o),
        .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_data_i(r_data_i),
        .w_valid_o(fp_w_valid_o), .w_addr_o(fp_w_addr_o), .w_data_o(fp_w_data_o),
        .w_len_o(fp_w_len_o), .w_size_o(fp_w_size_o),
        .w_ready_i(w_ready_i), .w_last_i(w_last_i),
        .rd_grant_o(fp_rd_grant), .wr_grant_o(fp_wr_grant),
        .rd_err_o(fp_rd_err), .wr_err_o(fp_wr_err)
    );

    function automatic logic [AW-1:0] r_addr_of(input int i);
        return AW'(32'h1000 + i * 32'h100);
    endfunction
    function automatic logic [AW-1:0] w_addr_of(input int i);
        return AW'(32'h2000 + i * 32'h100);
    endfunction
    function automatic logic [DW-1:0] w_data_of(input int i);
        return DW'(32'hD000 + i);
    endfunction
    function automatic logic [7:0] r_size_of(input int i);
        return 8'(32'h10 + i);
    endfunction
    function automatic logic [7:0] w_size_of(input int i);
        return 8'(32'h20 + i);
    endfunction

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        m_r_valid = '0;
        m_w_valid = '0;
        r_ready_i = 1'b0;
        r_last_i  = 1'b0;
        w_ready_i = 1'b0;
        w_last_i  = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_r_ready"},  m_r_ready,  '0);
        check({tag, "_m_r_last"},   m_r_last,   '0);
        check({tag, "_m_r_data"},   m_r_data,   '0);
        check({tag, "_m_w_ready"},  m_w_ready,  '0);
        check({tag, "_m_w_last"},   m_w_last,   '0);
        check({tag, "_r_valid_o"},  r_valid_o,  '0);
        check({tag, "_r_addr_o"},   r_addr_o,   '0);
        check({tag, "_r_len_o"},    r_len_o,    '0);
        check({tag, "_r_size_o"},   r_size_o,   '0);
        check({tag, "_w_valid_o"},  w_valid_o,  '0);
        check({tag, "_w_addr_o"},   w_addr_o,   '0);
        check({tag, "_w_data_o"},   w_data_o,   '0);
        check({tag, "_w_len_o"},    w_len_o,    '0);
        check({tag, "_w_size_o"},   w_size_o,   '0);
        check({tag, "_rd_grant"},   rd_grant_o, '0);
        check({tag, "_wr_grant"},   wr_grant_o, '0);
        check({tag, "_rd_err"},     rd_err_o,   '0);
        check({tag, "_wr_err"},     wr_err_o,   '0);
    endtask

    // One row per clock: inputs for that cycle and what the read channel
    // must show during it (state from earlier edges, strobes from this cycle).
    typedef struct {
        logic       rst;
        logic [2:0] valid;
        logic       ready;
        logic       last;
        logic [2:0] exp_grant;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] exp_addr;
        logic [7:0]    exp_size;

        for (int i = 0; i < N; i++) begin
            m_r_addr[i*AW +: AW] = r_addr_of(i);
            m_w_addr[i*AW +: AW] = w_addr_of(i);
            m_w_data[i*DW +: DW] = w_data_of(i);
            m_r_size[i*8 +: 8]   = r_size_of(i);
            m_w_size[i*8 +: 8]   = w_size_of(i);
        end
        m_r_len   = '0;
        m_w_len   = '0;
        m_r_valid = '0;
        m_w_valid = '0;
        r_ready_i = 1'b0;
        r_last_i  = 1'b0;
        w_ready_i = 1'b0;
        w_last_i  = 1'b0;
        r_data_i  = 16'hBEEF;
        rst       = 1'b1;
        cycle();
        cycle();

        // Reset with all read requests held, then round-robin over len=0
        // bursts with one idle bubble between grants.
        //            rst   valid   rdy   last  grant   vld   err
        vecs[0] = '{1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 3'b111, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0};

        for (int k = 0; k < 10; k++) begin
            rst       = vecs[k].rst;
            m_r_valid = vecs[k].valid;
            r_ready_i = vecs[k].ready;
            r_last_i  = vecs[k].last;
            settle();
            exp_addr = '0;
            exp_size = '0;
            for (int i = 0; i < N; i++) begin
                if (vecs[k].exp_grant[i]) begin
                    exp_addr = r_addr_of(i);
                    exp_size = r_size_of(i);
                end
            end
            check($sformatf("vec%0d_grant", k), rd_grant_o, vecs[k].exp_grant);
            check($sformatf("vec%0d_valid_o", k), r_valid_o, vecs[k].exp_valid);
            check($sformatf("vec%0d_err", k), rd_err_o, vecs[k].exp_err);
            check($sformatf("vec%0d_m_ready", k), m_r_ready,
                  vecs[k].exp_grant & {3{vecs[k].ready}});
            check($sformatf("vec%0d_m_last", k), m_r_last,
                  vecs[k].exp_grant & {3{vecs[k].last}});
            check($sformatf("vec%0d_m_data", k), m_r_data,
                  (vecs[k].exp_grant != 3'b000) ? 16'hBEEF : 16'h0000);
            check($sformatf("vec%0d_addr", k), r_addr_o, exp_addr);
            check($sformatf("vec%0d_size", k), r_size_o, exp_size);
            cycle();
        end

        // Fixed priority: masters 1,2 request, master 0 joins mid-burst.
        do_reset();
        m_r_len   = {8'd1, 8'd1, 8'd1};
        m_r_valid = 3'b110;
        cycle();
        m_r_valid = 3'b111;
        r_ready_i = 1'b1;
        settle();
        check("fp_first_grant", fp_rd_grant, 3'b010);
        check("rr_first_grant", rd_grant_o, 3'b010);
        cycle();
        r_last_i = 1'b1;
        settle();
        check("fp_m_last", fp_m_r_last, 3'b010);
        cycle();
        r_ready_i = 1'b0;
        r_last_i  = 1'b0;
        settle();
        check("fp_bubble", fp_rd_grant, 3'b000);
        cycle();
        settle();
        check("fp_master0_next", fp_rd_grant, 3'b001);
        check("rr_master2_next", rd_grant_o, 3'b100);
        check("fp_no_err", fp_rd_err, 1'b0);

        // Concurrent channels: master 0 reads len=3, master 2 writes len=1.
        do_reset();
        m_r_len   = {8'd0, 8'd0, 8'd3};
        m_w_len   = {8'd1, 8'd0, 8'd0};
        m_r_valid = 3'b001;
        m_w_valid = 3'b100;
        cycle();
        r_ready_i = 1'b1;
        w_ready_i = 1'b1;
        settle();
        check("cc_rd_grant", rd_grant_o, 3'b001);
        check("cc_wr_grant", wr_grant_o, 3'b100);
        check("cc_r_valid_o", r_valid_o, 1'b1);
        check("cc_w_valid_o", w_valid_o, 1'b1);
        check("cc_r_addr", r_addr_o, r_addr_of(0));
        check("cc_r_len", r_len_o, 8'd3);
        check("cc_w_addr", w_addr_o, w_addr_of(2));
        check("cc_w_data", w_data_o, w_data_of(2));
        check("cc_w_size", w_size_o, w_size_of(2));
        check("cc_w_len", w_len_o, 8'd1);
        cycle();
        w_last_i = 1'b1;
        settle();
        check("cc_m_w_ready", m_w_ready, 3'b100);
        check("cc_m_w_last", m_w_last, 3'b100);
        cycle();
        w_ready_i = 1'b0;
        w_last_i  = 1'b0;
        m_w_valid = 3'b000;
        settle();
        check("cc_wr_done", wr_grant_o, 3'b000);
        check("cc_rd_still", rd_grant_o, 3'b001);
        cycle();
        r_last_i = 1'b1;
        settle();
        check("cc_m_r_last", m_r_last, 3'b001);
        cycle();
        r_ready_i = 1'b0;
        r_last_i  = 1'b0;
        m_r_valid = 3'b000;
        settle();
        check("cc_rd_done", rd_grant_o, 3'b000);
        check("cc_rd_err", rd_err_o, 1'b0);
        check("cc_wr_err", wr_err_o, 1'b0);

        // Write overrun: len=0 beat without last sets err, burst ends on last.
        do_reset();
        m_w_len   = '0;
        m_w_valid = 3'b001;
        cycle();
        w_ready_i = 1'b1;
        settle();
        check("ov_grant", wr_grant_o, 3'b001);
        check("ov_err_before", wr_err_o, 1'b0);
        cycle();
        w_last_i = 1'b1;
        settle();
        check("ov_err_set", wr_err_o, 1'b1);
        check("ov_grant_held", wr_grant_o, 3'b001);
        cycle();
        w_ready_i = 1'b0;
        w_last_i  = 1'b0;
        m_w_valid = 3'b000;
        settle();
        check("ov_done", wr_grant_o, 3'b000);
        check("ov_err_sticky", wr_err_o, 1'b1);

        // Cancel before any beat, then an early-last burst.
        do_reset();
        m_r_len   = {8'd3, 8'd3, 8'd3};
        m_r_valid = 3'b010;
        cycle();
        m_r_valid = 3'b000;
        settle();
        check("cx_grant", rd_grant_o, 3'b010);
        check("cx_valid_o", r_valid_o, 1'b0);
        cycle();
        m_r_valid = 3'b110;
        settle();
        check("cx_cancelled", rd_grant_o, 3'b000);
        cycle();
        r_ready_i = 1'b1;
        settle();
        check("cx_ptr_kept", rd_grant_o, 3'b010);
        cycle();
        cycle();
        r_last_i = 1'b1;
        settle();
        check("er_not_yet", rd_err_o, 1'b0);
        cycle();
        r_ready_i = 1'b0;
        r_last_i  = 1'b0;
        m_r_valid = 3'b000;
        settle();
        check("er_set", rd_err_o, 1'b1);
        check("er_done", rd_grant_o, 3'b000);
        cycle();
        r_ready_i = 1'b1;
        r_last_i  = 1'b1;
        cycle();
        r_ready_i = 1'b0;
        r_last_i  = 1'b0;
        cycle();
        settle();
        check("er_sticky", rd_err_o, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        settle();
        check("er_cleared", rd_err_o, 1'b0);

        // Reset in the middle of both bursts.
        do_reset();
        m_r_len   = {8'd3, 8'd3, 8'd3};
        m_w_len   = {8'd3, 8'd3, 8'd3};
        m_r_valid = 3'b111;
        m_w_valid = 3'b111;
        cycle();
        r_ready_i = 1'b1;
        w_ready_i = 1'b1;
        settle();
        check("mr_rd_grant", rd_grant_o, 3'b001);
        check("mr_wr_grant", wr_grant_o, 3'b001);
        cycle();
        rst      = 1'b1;
        r_last_i = 1'b1;
        w_last_i = 1'b1;
        cycle();
        settle();
        check_all_zero("mr");
        rst       = 1'b0;
        r_ready_i = 1'b0;
        r_last_i  = 1'b0;
        w_ready_i = 1'b0;
        w_last_i  = 1'b0;
        cycle();
        settle();
        check("mr_regrant", rd_grant_o, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
